// File: rtl/mainmem_arbiter.sv
// mainmem_arbiter: round-robin sharing of one single-port main memory between port A (core0) and port B (host loader/debug).
//   clk, reset_b                    clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata       port A request (held stable until a_ack)
//   a_ack, a_rvalid, a_rdata        port A grant, read-return strobe and data (1-cycle latency)
//   b_*                             same as port A, for port B
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory array interface
//   a_max_wait, b_max_wait          sticky maximum consecutive wait cycles per port
module mainmem_arbiter #(
    parameter int WORD_WIDTH      = 32,
    parameter int MAIN_ADDR_WIDTH = 2,
    parameter int WAIT_CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       a_req,
    input  logic                       a_we,
    input  logic [MAIN_ADDR_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0]      a_wdata,
    output logic                       a_ack,
    output logic                       a_rvalid,
    output logic [WORD_WIDTH-1:0]      a_rdata,
    input  logic                       b_req,
    input  logic                       b_we,
    input  logic [MAIN_ADDR_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0]      b_wdata,
    output logic                       b_ack,
    output logic                       b_rvalid,
    output logic [WORD_WIDTH-1:0]      b_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [MAIN_ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0]      mem_wdata,
    input  logic [WORD_WIDTH-1:0]      mem_rdata,
    output logic [WAIT_CNT_WIDTH-1:0]  a_max_wait,
    output logic [WAIT_CNT_WIDTH-1:0]  b_max_wait
);
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
    port_t                     last_grant, rd_owner;
    logic                      rd_pending;
    logic                      grant_a, grant_b;
    logic [WAIT_CNT_WIDTH-1:0] wait_a, wait_b;
    // A wins alone or on a tie after B; B takes whatever A does not.
    assign grant_a   = reset_b && a_req && (!b_req || last_grant == PORT_B);
    assign grant_b   = reset_b && b_req && !grant_a;
    assign a_ack     = grant_a;
    assign b_ack     = grant_b;
    assign mem_en    = grant_a || grant_b;
    assign mem_we    = grant_a ? a_we : grant_b ? b_we : 1'b0;
    assign mem_addr  = grant_b ? b_addr : a_addr;
    assign mem_wdata = grant_b ? b_wdata : a_wdata;
    assign a_rvalid  = reset_b && rd_pending && rd_owner == PORT_A;
    assign b_rvalid  = reset_b && rd_pending && rd_owner == PORT_B;
    assign a_rdata   = mem_rdata;
    assign b_rdata   = mem_rdata;
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            last_grant <= PORT_B;
            rd_owner   <= PORT_A;
            rd_pending <= 1'b0;
            wait_a     <= '0;
            wait_b     <= '0;
            a_max_wait <= '0;
            b_max_wait <= '0;
        end else begin
            last_grant <= grant_b ? PORT_B : grant_a ? PORT_A : last_grant;
            rd_owner   <= grant_b ? PORT_B : grant_a ? PORT_A : rd_owner;
            rd_pending <= mem_en && !mem_we;
            // A wait run ends on ack or when the request is withdrawn.
            wait_a     <= (a_req && !grant_a) ? ((&wait_a) ? wait_a : wait_a + 1'b1) : '0;
            wait_b     <= (b_req && !grant_b) ? ((&wait_b) ? wait_b : wait_b + 1'b1) : '0;
            a_max_wait <= (wait_a > a_max_wait) ? wait_a : a_max_wait;
            b_max_wait <= (wait_b > b_max_wait) ? wait_b : b_max_wait;
        end
    end
endmodule

// File: tb/tb_mainmem_arbiter.sv
// tb_mainmem_arbiter: directed self-checking bench for mainmem_arbiter with a 4-word memory model.
module tb_mainmem_arbiter;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [1:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_ack, a_rvalid, b_ack, b_rvalid, mem_en, mem_we;
    logic [31:0] a_rdata, b_rdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_addr;
    logic [7:0]  a_max_wait, b_max_wait;
    logic        s_a_req = 1'b0, s_a_ack, s_a_rvalid, s_b_ack, s_b_rvalid, s_mem_en, s_mem_we;
    logic [31:0] s_a_rdata, s_b_rdata, s_mem_wdata;
    logic [1:0]  s_mem_addr, s_a_max_wait, s_b_max_wait;
    logic [31:0] mem [4];
    logic        preload = 1'b1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) mem[1] <= 32'hDEADBEEF;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= mem[mem_addr];
    end

    mainmem_arbiter dut (
        .clk(clk), .reset_b(reset_b),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .a_max_wait(a_max_wait), .b_max_wait(b_max_wait)
    );

    mainmem_arbiter #(.WORD_WIDTH(32), .MAIN_ADDR_WIDTH(2), .WAIT_CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset_b(reset_b),
        .a_req(s_a_req), .a_we(1'b0), .a_addr(2'd0), .a_wdata(32'd0),
        .a_ack(s_a_ack), .a_rvalid(s_a_rvalid), .a_rdata(s_a_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(2'd0), .b_wdata(32'd0),
        .b_ack(s_b_ack), .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(32'd0), .a_max_wait(s_a_max_wait), .b_max_wait(s_b_max_wait)
    );

    task automatic apply_reset;
        @(negedge clk);
        reset_b = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_b = 1'b0; a_req = 1'b1; b_req = 1'b1;
        #1;
        checks++; if ({a_ack, b_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", {a_ack, b_ack}); end
        checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b want 00", {mem_en, mem_we}); end
        checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {a_rvalid, b_rvalid}); end
        checks++; if ({a_max_wait, b_max_wait} !== 16'h0) begin errors++; $display("FAIL reset_max_wait: got %h want 0000", {a_max_wait, b_max_wait}); end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_read_a;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
        #1;
        checks++; if ({a_ack, b_ack} !== 2'b10) begin errors++; $display("FAIL read_ack: got %b want 10", {a_ack, b_ack}); end
        checks++; if ({mem_en, mem_we, mem_addr} !== 4'b1001) begin errors++; $display("FAIL read_mem: got en/we/addr %b want 1001", {mem_en, mem_we, mem_addr}); end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++; if ({a_rvalid, b_rvalid} !== 2'b10) begin errors++; $display("FAIL read_rvalid: got %b want 10", {a_rvalid, b_rvalid}); end
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", a_rdata); end
    endtask

    task automatic test_round_robin;
        apply_reset();
        @(negedge clk);
        a_req = 1'b1; a_addr = 2'd1; b_req = 1'b1; b_we = 1'b0; b_addr = 2'd0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if ({a_ack, b_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack cycle %0d: got %b want %b", i, {a_ack, b_ack}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            if (i > 0) begin
                checks++; if ({a_rvalid, b_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rvalid cycle %0d: got %b", i, {a_rvalid, b_rvalid}); end
            end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (a_max_wait !== 8'd1) begin errors++; $display("FAIL rr_a_max_wait: got %0d want 1", a_max_wait); end
        checks++; if (b_max_wait !== 8'd1) begin errors++; $display("FAIL rr_b_max_wait: got %0d want 1", b_max_wait); end
    endtask

    task automatic test_write_read_b;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 2'd2; b_wdata = 32'h12345678;
        #1;
        checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", b_ack); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1110, 32'h12345678}) begin errors++; $display("FAIL wr_mem: got %b %h want 1110 12345678", {mem_en, mem_we, mem_addr}, mem_wdata); end
        @(negedge clk);
        b_we = 1'b0;
        #1;
        checks++; if ({b_ack, b_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_after_wr_ack: got ack/rvalid %b want 10", {b_ack, b_rvalid}); end
        @(negedge clk);
        b_req = 1'b0;
        #1;
        checks++; if ({a_rvalid, b_rvalid} !== 2'b01) begin errors++; $display("FAIL rd_after_wr_rvalid: got %b want 01", {a_rvalid, b_rvalid}); end
        checks++; if (b_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_after_wr_data: got %h want 12345678", b_rdata); end
    endtask

    task automatic test_lone_b;
        apply_reset();
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({a_ack, b_ack} !== 2'b01) begin errors++; $display("FAIL lone_b_ack cycle %0d: got %b want 01", i, {a_ack, b_ack}); end
            @(negedge clk);
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
        #1;
        checks++; if (b_max_wait !== 8'd0) begin errors++; $display("FAIL lone_b_max_wait: got %0d want 0", b_max_wait); end
        checks++; if ({a_ack, b_ack} !== 2'b10) begin errors++; $display("FAIL tie_after_b: got %b want 10", {a_ack, b_ack}); end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++; if ({a_ack, b_ack} !== 2'b01) begin errors++; $display("FAIL b_after_a: got %b want 01", {a_ack, b_ack}); end
        @(negedge clk);
        b_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
        #1;
        checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b want 1", a_ack); end
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        checks++; if ({a_rvalid, mem_en, a_ack} !== 3'b000) begin errors++; $display("FAIL mid_in_reset: got rvalid/en/ack %b want 000", {a_rvalid, mem_en, a_ack}); end
        @(negedge clk);
        reset_b = 1'b1; a_req = 1'b0;
        #1;
        checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_after_release: got %b want 00", {a_rvalid, b_rvalid}); end
        @(negedge clk);
        #1;
        checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_after_release2: got %b want 00", {a_rvalid, b_rvalid}); end
        a_req = 1'b1; b_req = 1'b1;
        #1;
        checks++; if ({a_ack, b_ack} !== 2'b10) begin errors++; $display("FAIL mid_first_tie: got %b want 10", {a_ack, b_ack}); end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_saturation;
        logic [1:0] exp_w, exp_m;
        @(negedge clk);
        s_a_req = 1'b1;
        force dut2.grant_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            exp_w = (k > 3) ? 2'd3 : 2'(k);
            exp_m = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            checks++; if (s_a_ack !== 1'b0) begin errors++; $display("FAIL sat_ack cycle %0d: got %b want 0", k, s_a_ack); end
            checks++; if (dut2.wait_a !== exp_w) begin errors++; $display("FAIL sat_wait cycle %0d: got %0d want %0d", k, dut2.wait_a, exp_w); end
            checks++; if (s_a_max_wait !== exp_m) begin errors++; $display("FAIL sat_max cycle %0d: got %0d want %0d", k, s_a_max_wait, exp_m); end
        end
        s_a_req = 1'b0;
        release dut2.grant_a;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        preload = 1'b0;
        test_reset();
        test_read_a();
        test_round_robin();
        test_write_read_b();
        test_lone_b();
        test_reset_mid();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
